alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width in bits, legal range 4..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand/op presented.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 A, B  input  DATA_WIDTH each  operands.
REQ-007 ALUop  input  4  operation code.
REQ-008 out_valid  output  1  Result/flags valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 Result  output  DATA_WIDTH  registered result.
REQ-011 Overflow, CarryOut, Zero  output  1 each  registered flags.

Function
REQ-012 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 SLTU, 0100 XOR, 0101 NOR, 0110 SUB, 0111 SLT, 1000 MUL (low DATA_WIDTH bits of unsigned A*B); all others produce Result 0, flags 0 except Zero=1.
REQ-013 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-014 FSM states IDLE, MUL_BUSY, DONE; IDLE->DONE on non-MUL accept; IDLE->MUL_BUSY on MUL accept; MUL_BUSY->DONE after DATA_WIDTH iterations; DONE->IDLE on output transfer without new accept; DONE->DONE/MUL_BUSY on output transfer with simultaneous accept.
REQ-015 in_ready = (state==IDLE) | (state==DONE & out_ready); low throughout MUL_BUSY.
REQ-016 Non-MUL latency: accepted in cycle N, out_valid high with result in cycle N+1; sustained throughput one op per cycle when out_ready held high.
REQ-017 MUL: shift-add, one bit of B per cycle, LSB first; out_valid asserts exactly DATA_WIDTH+1 cycles after accept.
REQ-018 Operands, opcode and Result/flags are captured at accept; later changes on A/B/ALUop do not affect an op in flight.
REQ-019 Result and flags hold stable while out_valid=1 and out_ready=0.
REQ-020 ADD/SUB/SLT/SLTU use one DATA_WIDTH+1-bit adder: SUB-class (SUB, SLT, SLTU) adds ~B plus carry-in 1.
REQ-021 CarryOut = adder carry XOR sub-class (i.e. borrow on subtract); Overflow = carry into MSB XOR carry out of MSB; both 0 for non-adder ops.
REQ-022 SLT Result = {0..., Overflow^sum[MSB]}; SLTU Result = {0..., CarryOut}.
REQ-023 Zero = (Result == 0) for every op, registered with Result.
REQ-024 MUL flags: Overflow=0, CarryOut=1 iff upper DATA_WIDTH bits of full product nonzero.

Reset
REQ-025 rst high at a clock edge: state->IDLE, out_valid=0, Result=0, Overflow=0, CarryOut=0, Zero=1, multiply iteration counter=0.
REQ-026 rst during MUL_BUSY or DONE aborts the op; no result is ever delivered for it.
REQ-027 in_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-028 Macro ALU_MC_MUL_EN: defined -> MUL_BUSY state, iteration counter and shift-add datapath are present per REQ-017/024.
REQ-029 ALU_MC_MUL_EN undefined -> opcode 1000 treated as undefined per REQ-012 with single-cycle latency; no MUL_BUSY state or multiply logic synthesised.

Structure
REQ-030 Shared package alu_pkg holds opcode constants, FSM state encoding, and opcode width 4.
REQ-031 Sub-module alu_mc_adder (DATA_WIDTH parameter, inputs A, B, sub; outputs sum, CarryOut, Overflow) is instantiated once; everything else in alu_mc.

Verification (DATA_WIDTH=32 unless stated)
REQ-032 ADD 0x7FFFFFFF+1, out_ready=1 -> next cycle Result 0x80000000, Overflow=1, CarryOut=0, Zero=0.
REQ-033 SUB 5-5 then SLT 0xFFFFFFFF,1 then SLTU 0xFFFFFFFF,1 back-to-back -> Result 0/Zero=1, then 1, then 0; one result per cycle.
REQ-034 MUL 0x10000*0x10000 with ALU_MC_MUL_EN -> in_ready low 32 cycles, out_valid on cycle 33, Result 0, CarryOut=1, Zero=1; without macro -> Result 0 at cycle 1.
REQ-035 Backpressure: ADD 3+4 with out_ready=0 for 5 cycles while A/B change -> Result 7 held, in_ready=0, single transfer when out_ready rises.
REQ-036 rst asserted mid-MUL at iteration 10 -> out_valid=0, Zero=1, in_ready=1 next cycle after release, no stale result.
REQ-037 DATA_WIDTH=8: ADD 0xFF+0x01 -> Result 0x00, CarryOut=1, Overflow=0, Zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, opcode width and FSM state encoding shared by the alu_mc slice.
package alu_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
   localparam logic [OP_W-1:0] OP_SLTU = 4'b0011;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
   localparam logic [OP_W-1:0] OP_NOR  = 4'b0101;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
   localparam logic [OP_W-1:0] OP_SLT  = 4'b0111;
   localparam logic [OP_W-1:0] OP_MUL  = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_BUSY = 2'd1,
      ST_DONE     = 2'd2
   } state_t;

   // Subtract-class ops feed ~B and a carry-in of 1 into the shared adder.
   function automatic logic is_sub_op(input logic [OP_W-1:0] op);
      return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/op input channel and result/flag output channel of alu_mc.
interface alu_mc_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     A;
   logic [DATA_WIDTH-1:0]     B;
   logic [alu_pkg::OP_W-1:0]  ALUop;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_WIDTH-1:0]     Result;
   logic                      Overflow;
   logic                      CarryOut;
   logic                      Zero;

   modport master (
      output in_valid, A, B, ALUop, out_ready,
      input  in_ready, out_valid, Result, Overflow, CarryOut, Zero
   );

   modport slave (
      input  in_valid, A, B, ALUop, out_ready,
      output in_ready, out_valid, Result, Overflow, CarryOut, Zero
   );
endinterface

// File: rtl/alu_mc_adder.sv
// alu_mc_adder: single DATA_WIDTH+1-bit add/subtract with borrow-style carry and signed overflow.
module alu_mc_adder #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  sub,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  CarryOut,
   output logic                  Overflow
);
   logic [DATA_WIDTH-1:0] b_eff;
   logic [DATA_WIDTH:0]   full;
   logic                  c_into_msb;

   assign b_eff = sub ? ~B : B;
   assign full  = {1'b0, A} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub};
   assign sum   = full[DATA_WIDTH-1:0];

   // The carry into the MSB is recovered from the MSB sum bit and its two addend bits.
   assign c_into_msb = A[DATA_WIDTH-1] ^ b_eff[DATA_WIDTH-1] ^ full[DATA_WIDTH-1];
   assign Overflow   = c_into_msb ^ full[DATA_WIDTH];
   assign CarryOut   = full[DATA_WIDTH] ^ sub;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with registered result/flags driven by an IDLE/MUL_BUSY/DONE FSM.
// Define ALU_MC_MUL_EN to build the shift-add multiplier for opcode 1000.
module alu_mc
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic    clk,
   input  logic    rst,
   alu_mc_if.slave bus,
   output state_t  state_o
);
   localparam int W = DATA_WIDTH;

   state_t       state_q, state_d;
   logic [W-1:0] result_q, result_d;
   logic         ovf_q, ovf_d, cout_q, cout_d, zero_q, zero_d;
   logic         accept, is_mul;
   logic [W-1:0] add_a, add_b, add_sum;
   logic         add_sub, add_cout, add_ovf;
   logic [W-1:0] op_res;
   logic         op_ovf, op_cout;

   // An op transfers in on in_valid & in_ready; a result transfers out on out_valid & out_ready.
   assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
   assign bus.out_valid = (state_q == ST_DONE);
   assign accept        = bus.in_valid && bus.in_ready;

`ifdef ALU_MC_MUL_EN
   logic [2*W-1:0] prod_q, prod_d, prod_step;
   logic [W-1:0]   mcand_q, mcand_d;
   logic [6:0]     cnt_q, cnt_d;
   logic           mul_last;

   assign is_mul   = (bus.ALUop == OP_MUL);
   assign mul_last = (cnt_q == 7'(W-1));
   // {hi, lo} holds partial product over the unconsumed multiplier bits; shift right each step.
   assign prod_step = {add_cout, add_sum, prod_q[W-1:1]};

   always_comb begin
      add_a   = bus.A;
      add_b   = bus.B;
      add_sub = is_sub_op(bus.ALUop);
      if (state_q == ST_MUL_BUSY) begin
         add_a   = prod_q[2*W-1:W];
         add_b   = prod_q[0] ? mcand_q : '0;
         add_sub = 1'b0;
      end
   end

   always_comb begin
      prod_d  = prod_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      if (accept && is_mul) begin
         prod_d  = {{W{1'b0}}, bus.B};
         mcand_d = bus.A;
         cnt_d   = '0;
      end else if (state_q == ST_MUL_BUSY) begin
         prod_d = prod_step;
         cnt_d  = mul_last ? '0 : cnt_q + 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q  <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
      end else begin
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign is_mul  = 1'b0;
   assign add_a   = bus.A;
   assign add_b   = bus.B;
   assign add_sub = is_sub_op(bus.ALUop);
`endif

   alu_mc_adder #(.DATA_WIDTH(W)) u_adder (
      .A        (add_a),
      .B        (add_b),
      .sub      (add_sub),
      .sum      (add_sum),
      .CarryOut (add_cout),
      .Overflow (add_ovf)
   );

   always_comb begin
      op_res  = '0;
      op_ovf  = 1'b0;
      op_cout = 1'b0;
      case (bus.ALUop)
         OP_AND: op_res = bus.A & bus.B;
         OP_OR:  op_res = bus.A | bus.B;
         OP_XOR: op_res = bus.A ^ bus.B;
         OP_NOR: op_res = ~(bus.A | bus.B);
         OP_ADD, OP_SUB: begin
            op_res  = add_sum;
            op_ovf  = add_ovf;
            op_cout = add_cout;
         end
         OP_SLT: begin
            op_res  = {{(W-1){1'b0}}, add_ovf ^ add_sum[W-1]};
            op_ovf  = add_ovf;
            op_cout = add_cout;
         end
         OP_SLTU: begin
            op_res  = {{(W-1){1'b0}}, add_cout};
            op_ovf  = add_ovf;
            op_cout = add_cout;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      cout_d   = cout_q;
      zero_d   = zero_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept)
               state_d = is_mul ? ST_MUL_BUSY : ST_DONE;
            else if (state_q == ST_DONE && bus.out_ready)
               state_d = ST_IDLE;
         end
         default: ;
      endcase
      if (accept && !is_mul) begin
         result_d = op_res;
         ovf_d    = op_ovf;
         cout_d   = op_cout;
         zero_d   = (op_res == '0);
      end
`ifdef ALU_MC_MUL_EN
      if (state_q == ST_MUL_BUSY && mul_last) begin
         state_d  = ST_DONE;
         result_d = prod_step[W-1:0];
         ovf_d    = 1'b0;
         cout_d   = |prod_step[2*W-1:W];
         zero_d   = (prod_step[W-1:0] == '0);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         cout_q   <= cout_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.Result   = result_q;
   assign bus.Overflow = ovf_q;
   assign bus.CarryOut = cout_q;
   assign bus.Zero     = zero_q;
   assign state_o      = state_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (32-bit instance plus an 8-bit instance).
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;

   logic   clk;
   logic   rst;
   state_t st32, st8;
   int     n_checks = 0;
   int     n_pass   = 0;
   int     cyc      = 0;
   logic   rand_bp  = 1'b0;
   logic [W+2:0] exp_q[$];

   alu_mc_if #(.DATA_WIDTH(W)) bus ();
   alu_mc_if #(.DATA_WIDTH(8)) bus8 ();

   alu_mc #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .state_o(st32));
   alu_mc #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .state_o(st8));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached checks=%0d", n_checks);
      $fatal(1, "watchdog timeout");
   end

   always @(posedge clk) begin
      if (rand_bp) begin
         #1;
         bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] a, b);
      logic [W-1:0]   r, d;
      logic           o, c;
      logic [W:0]     s;
      logic [2*W-1:0] p;
      r = '0; o = 1'b0; c = 1'b0;
      d = a - b;
      s = {1'b0, a} + {1'b0, b};
      p = '0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0100: r = a ^ b;
         4'b0101: r = ~(a | b);
         4'b0010: begin
            r = s[W-1:0];
            c = s[W];
            o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'b0110, 4'b0111, 4'b0011: begin
            c = (a < b);
            o = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
            if (op == 4'b0110)      r = d;
            else if (op == 4'b0111) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            else                    r = (a < b) ? 32'd1 : 32'd0;
         end
`ifdef ALU_MC_MUL_EN
         4'b1000: begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            r = p[W-1:0];
            c = |p[2*W-1:W];
         end
`endif
         default: ;
      endcase
      return {r, o, c, (r == '0)};
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_result got=%h ovf=%b cout=%b zero=%b required=none",
                     bus.Result, bus.Overflow, bus.CarryOut, bus.Zero);
         end else begin
            logic [W+2:0] e, g;
            e = exp_q.pop_front();
            g = {bus.Result, bus.Overflow, bus.CarryOut, bus.Zero};
            if (g !== e)
               $display("FAIL result got=%h/o%b c%b z%b required=%h/o%b c%b z%b",
                        g[W+2:3], g[2], g[1], g[0], e[W+2:3], e[2], e[1], e[0]);
            else
               n_pass++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      bus.in_valid = 1'b1;
      bus.ALUop    = op;
      bus.A        = a;
      bus.B        = b;
      n = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         $display("FAIL send_timeout op=%h in_ready=%b required=1", op, bus.in_ready);
      end else begin
         exp_q.push_back(model(op, a, b));
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.ALUop = '0; bus.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.ALUop = '0; bus8.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b required=0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.Result !== 32'h0) $display("FAIL rst_result got=%h required=0", bus.Result); else n_pass++;
      n_checks++; if ({bus.Overflow, bus.CarryOut, bus.Zero} !== 3'b001)
         $display("FAIL rst_flags got=%b required=001", {bus.Overflow, bus.CarryOut, bus.Zero}); else n_pass++;
      n_checks++; if (st32 !== ST_IDLE || st8 !== ST_IDLE) $display("FAIL rst_state got=%0d/%0d required=0/0", st32, st8); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b required=1", bus.in_ready); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_add_overflow();
      bus.out_ready = 1'b1;
      send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      n_checks++; if (bus.out_valid !== 1'b1 || bus.Result !== 32'h8000_0000)
         $display("FAIL add_ovf_latency valid=%b result=%h required=1/80000000", bus.out_valid, bus.Result); else n_pass++;
      drain();
   endtask

   task automatic test_back_to_back();
      int t0;
      bus.out_ready = 1'b1;
      t0 = cyc;
      send(OP_SUB,  32'd5,         32'd5);
      send(OP_SLT,  32'hFFFF_FFFF, 32'd1);
      send(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
      n_checks++; if (cyc - t0 !== 3) $display("FAIL b2b_cycles got=%0d required=3", cyc - t0); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (exp_q.size() !== 0 || bus.out_valid !== 1'b0)
         $display("FAIL b2b_drain pending=%0d valid=%b required=0/0", exp_q.size(), bus.out_valid); else n_pass++;
   endtask

   task automatic test_logic_ops();
      logic [3:0]   ops [8] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SUB, 4'b1001, 4'b1111, OP_ADD};
      logic [W-1:0] as  [8] = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
                                32'd1, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [W-1:0] bs  [8] = '{32'h0FF0_FFFF, 32'h0FF0_FFFF, 32'h0FF0_FFFF, 32'h0FF0_FFFF,
                                32'd2, 32'h1, 32'hFFFF_FFFF, 32'h1};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(ops[i], as[i], bs[i]);
      drain();
      n_checks++; if (exp_q.size() !== 0) $display("FAIL ops_drain pending=%0d required=0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      send(OP_ADD, 32'd3, 32'd4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.Result !== 32'd7 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.Zero !== 1'b0)
            $display("FAIL bp_hold cyc=%0d result=%h valid=%b in_ready=%b zero=%b required=7/1/0/0",
                     i, bus.Result, bus.out_valid, bus.in_ready, bus.Zero);
         else n_pass++;
         @(posedge clk); #1;
         bus.A = $urandom;
         bus.B = $urandom;
         bus.ALUop = 4'($urandom_range(0, 15));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b0 || exp_q.size() !== 0)
         $display("FAIL bp_single valid=%b pending=%0d required=0/0", bus.out_valid, exp_q.size()); else n_pass++;
   endtask

   task automatic test_mul();
      int busy;
      bus.out_ready = 1'b1;
      send(OP_MUL, 32'h0001_0000, 32'h0001_0000);
`ifdef ALU_MC_MUL_EN
      busy = 0;
      @(negedge clk);
      while (bus.in_ready === 1'b0 && bus.out_valid === 1'b0 && busy < 100) begin
         busy++;
         @(negedge clk);
      end
      n_checks++; if (busy !== 32) $display("FAIL mul_busy_cycles got=%0d required=32", busy); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL mul_out_valid got=%b required=1", bus.out_valid); else n_pass++;
`else
      busy = 0;
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b1 || bus.Result !== 32'h0 || bus.Zero !== 1'b1 || busy !== 0)
         $display("FAIL mul_undef valid=%b result=%h zero=%b required=1/0/1", bus.out_valid, bus.Result, bus.Zero);
      else n_pass++;
`endif
      drain();
      send(OP_MUL, 32'hDEAD_BEEF, 32'h0000_0003);
      send(OP_MUL, 32'h0000_0007, 32'h0000_0009);
      drain();
      n_checks++; if (exp_q.size() !== 0) $display("FAIL mul_drain pending=%0d required=0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_reset_mid_mul();
      int stray;
      bus.out_ready = 1'b0;
      send(OP_MUL, 32'h1234_5678, 32'h0000_00FF);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      n_checks++; if (bus.out_valid !== 1'b0 || bus.Zero !== 1'b1 || bus.Result !== 32'h0 || st32 !== ST_IDLE)
         $display("FAIL abort_state valid=%b zero=%b result=%h state=%0d required=0/1/0/0",
                  bus.out_valid, bus.Zero, bus.Result, st32);
      else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL abort_in_ready got=%b required=1", bus.in_ready); else n_pass++;
      stray = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) stray++;
      end
      n_checks++; if (stray !== 0) $display("FAIL abort_stale stray_cycles=%0d required=0", stray); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_width8();
      bus8.out_ready = 1'b1;
      bus8.in_valid  = 1'b1;
      bus8.ALUop     = OP_ADD;
      bus8.A         = 8'hFF;
      bus8.B         = 8'h01;
      @(negedge clk);
      n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL w8_in_ready got=%b required=1", bus8.in_ready); else n_pass++;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      n_checks++;
      if (bus8.out_valid !== 1'b1 || bus8.Result !== 8'h00 ||
          {bus8.Overflow, bus8.CarryOut, bus8.Zero} !== 3'b011)
         $display("FAIL w8_add valid=%b result=%h ovf/cout/zero=%b required=1/00/011",
                  bus8.out_valid, bus8.Result, {bus8.Overflow, bus8.CarryOut, bus8.Zero});
      else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (bus8.out_valid !== 1'b0) $display("FAIL w8_single got=%b required=0", bus8.out_valid); else n_pass++;
   endtask

   task automatic test_random();
      rand_bp = 1'b1;
      for (int i = 0; i < 30; i++) begin
         logic [3:0]   op;
         logic [W-1:0] a, b;
         op = 4'($urandom_range(0, 15));
         a  = pick_operand();
         b  = pick_operand();
         send(op, a, b);
      end
      rand_bp = 1'b0;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drain();
      n_checks++; if (exp_q.size() !== 0) $display("FAIL rand_drain pending=%0d required=0", exp_q.size()); else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_add_overflow();
      test_back_to_back();
      test_logic_ops();
      test_backpressure();
      test_mul();
      test_reset_mid_mul();
      test_width8();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
